// File: rtl/sample_acc_pkg.sv
// sample_acc_pkg: shared FSM state type and default sizing for sample_accumulator.
package sample_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_NUM_SAMPLES = 4;
endpackage

// File: rtl/sample_accumulator_adder.sv
// adder_nbit: unsigned n-bit ripple-carry adder with carry in/out.
module adder_nbit
  import sample_acc_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out
);
  logic c;
  always_comb begin
    c = carry_in;
    sum = '0;
    for (int k = 0; k < BIT_WIDTH; k++) begin
      sum[k] = a[k] ^ b[k] ^ c;
      c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    carry_out = c;
  end
endmodule

// File: rtl/sample_accumulator.sv
// sample_accumulator: sums NUM_SAMPLES valid/ready samples per frame with sticky overflow.
// Define ACC_SATURATE_EN to clamp the sum at all ones instead of wrapping.
module sample_accumulator
  import sample_acc_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic [BIT_WIDTH-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [BIT_WIDTH-1:0] acc_out,
  output logic                 result_valid,
  output logic                 overflow
);
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);
  state_t state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [BIT_WIDTH-1:0] acc_nx, add_a, sum, sum_eff;
  logic ovf_nx, carry, accept;
  assign data_ready = state != DONE;
  assign result_valid = state == DONE;
  assign accept = data_valid & data_ready & ~clear;
  // First sample of a frame loads directly, so the old total is masked off the adder.
  assign add_a = state == IDLE ? '0 : acc_out;
  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_add (
    .a        (add_a),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(carry)
  );
`ifdef ACC_SATURATE_EN
  assign sum_eff = carry ? '1 : sum;
`else
  assign sum_eff = sum;
`endif
  always_comb begin
    state_nx = state;
    count_nx = count;
    acc_nx = acc_out;
    ovf_nx = overflow;
    if (clear) begin
      state_nx = IDLE;
      count_nx = '0;
      acc_nx = '0;
      ovf_nx = 1'b0;
    end else if (state == DONE) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (accept) begin
      acc_nx = sum_eff;
      ovf_nx = (state == ACCUM && overflow) || carry;
      count_nx = count + CW'(1);
      state_nx = count == LAST ? DONE : ACCUM;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      count <= '0;
      acc_out <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      acc_out <= acc_nx;
      overflow <= ovf_nx;
    end
endmodule

// File: tb/tb_sample_accumulator.sv
// tb_sample_accumulator: directed self-checking bench for sample_accumulator (8-bit, 4 samples).
module tb_sample_accumulator;
  logic clk = 1'b0;
  logic n_rst, clear, data_valid, data_ready, result_valid, overflow;
  logic [7:0] data_in, acc_out;
  int tests = 0;
  int fails = 0;
`ifdef ACC_SATURATE_EN
  localparam logic [7:0] OVF_SUM = 8'd255;
`else
  localparam logic [7:0] OVF_SUM = 8'd44;
`endif

  sample_accumulator #(.BIT_WIDTH(8), .NUM_SAMPLES(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .acc_out     (acc_out),
    .result_valid(result_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [7:0] d);
    data_valid = v;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    clear = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    #2;
    tests++; if (acc_out !== 8'd0) begin fails++; $display("FAIL reset_acc got %0d want 0", acc_out); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %b want 0", result_valid); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
    tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", data_ready); end
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_basic;
    drive(1, 10);
    tests++; if (acc_out !== 8'd10) begin fails++; $display("FAIL basic_s1 got %0d want 10", acc_out); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_rv_early got %b want 0", result_valid); end
    drive(1, 20);
    tests++; if (acc_out !== 8'd30) begin fails++; $display("FAIL basic_s2 got %0d want 30", acc_out); end
    drive(1, 30);
    tests++; if (acc_out !== 8'd60) begin fails++; $display("FAIL basic_s3 got %0d want 60", acc_out); end
    tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_s3 got %b want 1", data_ready); end
    drive(1, 40);
    tests++; if (acc_out !== 8'd100) begin fails++; $display("FAIL basic_total got %0d want 100", acc_out); end
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL basic_rv got %b want 1", result_valid); end
    tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_done got %b want 0", data_ready); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b want 0", overflow); end
    drive(0, 0);
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL basic_rv_strobe got %b want 0", result_valid); end
    tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after got %b want 1", data_ready); end
    tests++; if (acc_out !== 8'd100) begin fails++; $display("FAIL basic_hold got %0d want 100", acc_out); end
  endtask

  task automatic test_overflow;
    drive(1, 200);
    tests++; if (acc_out !== 8'd200) begin fails++; $display("FAIL ovf_s1 got %0d want 200", acc_out); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_first_clear got %b want 0", overflow); end
    drive(1, 100);
    tests++; if (acc_out !== OVF_SUM) begin fails++; $display("FAIL ovf_s2 got %0d want %0d", acc_out, OVF_SUM); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", overflow); end
    drive(1, 0);
    drive(1, 0);
    tests++; if (acc_out !== OVF_SUM) begin fails++; $display("FAIL ovf_total got %0d want %0d", acc_out, OVF_SUM); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL ovf_rv got %b want 1", result_valid); end
    drive(0, 0);
  endtask

  task automatic test_back_to_back;
    drive(1, 10);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_ovf_cleared got %b want 0", overflow); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'd77);
      tests++; if (acc_out !== 8'd10) begin fails++; $display("FAIL b2b_stall1 got %0d want 10", acc_out); end
    end
    drive(1, 20);
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'd77);
      tests++; if (acc_out !== 8'd30) begin fails++; $display("FAIL b2b_stall2 got %0d want 30", acc_out); end
      tests++; if (dut.count !== 3'd2) begin fails++; $display("FAIL b2b_count_hold got %0d want 2", dut.count); end
    end
    drive(1, 30);
    drive(1, 40);
    tests++; if (acc_out !== 8'd100 || result_valid !== 1'b1) begin fails++; $display("FAIL b2b_f1 got %0d/%b want 100/1", acc_out, result_valid); end
    drive(1, 1);
    tests++; if (acc_out !== 8'd100) begin fails++; $display("FAIL b2b_f1_hold got %0d want 100", acc_out); end
    drive(1, 1);
    tests++; if (acc_out !== 8'd1) begin fails++; $display("FAIL b2b_f2_s1 got %0d want 1", acc_out); end
    drive(1, 1);
    drive(1, 1);
    drive(1, 1);
    tests++; if (acc_out !== 8'd4) begin fails++; $display("FAIL b2b_f2_total got %0d want 4", acc_out); end
    tests++; if (result_valid !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL b2b_f2_flags got rv=%b ovf=%b want 1/0", result_valid, overflow); end
    drive(0, 0);
  endtask

  task automatic test_clear;
    drive(1, 10);
    drive(1, 20);
    tests++; if (acc_out !== 8'd30) begin fails++; $display("FAIL clr_pre got %0d want 30", acc_out); end
    clear = 1'b1;
    drive(1, 99);
    clear = 1'b0;
    tests++; if (acc_out !== 8'd0) begin fails++; $display("FAIL clr_acc got %0d want 0", acc_out); end
    tests++; if (dut.count !== 3'd0) begin fails++; $display("FAIL clr_count got %0d want 0", dut.count); end
    tests++; if (data_ready !== 1'b1 || result_valid !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL clr_flags got rdy=%b rv=%b ovf=%b want 1/0/0", data_ready, result_valid, overflow); end
    drive(1, 5);
    tests++; if (acc_out !== 8'd5) begin fails++; $display("FAIL clr_fresh_s1 got %0d want 5", acc_out); end
    drive(1, 6);
    drive(1, 7);
    drive(1, 8);
    tests++; if (acc_out !== 8'd26 || result_valid !== 1'b1) begin fails++; $display("FAIL clr_fresh_total got %0d/%b want 26/1", acc_out, result_valid); end
    drive(0, 0);
  endtask

  task automatic test_async_reset;
    drive(1, 1);
    drive(1, 2);
    drive(1, 3);
    data_valid = 1'b0;
    tests++; if (acc_out !== 8'd6) begin fails++; $display("FAIL arst_pre got %0d want 6", acc_out); end
    #2 n_rst = 1'b0;
    #1;
    tests++; if (acc_out !== 8'd0 || overflow !== 1'b0) begin fails++; $display("FAIL arst_imm got acc=%0d ovf=%b want 0/0", acc_out, overflow); end
    tests++; if (data_ready !== 1'b1 || result_valid !== 1'b0) begin fails++; $display("FAIL arst_hs got rdy=%b rv=%b want 1/0", data_ready, result_valid); end
    @(posedge clk);
    #1 n_rst = 1'b1;
    drive(1, 50);
    drive(1, 60);
    drive(1, 70);
    drive(1, 75);
    tests++; if (acc_out !== 8'd255 || overflow !== 1'b0 || result_valid !== 1'b1) begin fails++; $display("FAIL arst_frame got %0d/ovf=%b/rv=%b want 255/0/1", acc_out, overflow, result_valid); end
    drive(0, 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_back_to_back;
    test_clear;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Sequential accumulator that sits directly downstream of the n-bit ripple adder in the datapath. It accepts a stream of unsigned samples over a valid/ready handshake and sums a fixed-length frame of NUM_SAMPLES samples through one adder instance. It presents the frame total with a one-cycle result strobe and a sticky overflow flag. Overflow handling is selected at compile time: wrap or saturate.

## Interface
- BIT_WIDTH, default 8: sample and accumulator width in bits.
- NUM_SAMPLES, default 4: samples per frame; must be at least 2.
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame abort; highest priority after reset.
- data_in  input  BIT_WIDTH  unsigned sample.
- data_valid  input  1  data_in is valid. The source holds data_in and data_valid until the sample is accepted.
- data_ready  output  1  block can accept a sample this cycle.
- acc_out  output  BIT_WIDTH  running or final sum, registered.
- result_valid  output  1  one-cycle strobe: acc_out holds the completed frame total.
- overflow  output  1  sticky; at least one add in the current or last frame produced a carry-out.

## Operation
- State machine states: IDLE, ACCUM, DONE.
- A sample is accepted on any rising edge where data_valid=1, data_ready=1 and clear=0.
- data_ready is 1 in IDLE and ACCUM, and 0 in DONE.
- IDLE, on accept:
  - acc_out <= data_in. The adder operand a is forced to 0 and carry_in is 0.
  - overflow <= 0, count <= 1, next state ACCUM.
  - acc_out keeps the previous frame total until this first accept.
- ACCUM, on accept:
  - acc_out <= acc_out + data_in through the adder; overflow <= overflow OR carry-out; count increments.
  - The accept that brings count to NUM_SAMPLES moves the FSM to DONE.
- DONE: result_valid=1 for exactly one cycle, then the FSM returns to IDLE unconditionally. acc_out and overflow are held.
- Counter width is $clog2(NUM_SAMPLES+1). The counter resets to 0 when the FSM enters IDLE.
- clear=1 in any state, on the next edge:
  - FSM goes to IDLE; acc_out=0, overflow=0, count=0.
  - A sample presented in the same cycle is not accepted.
  - If clear is asserted in the DONE cycle, result_valid is still 1 for that cycle.
- Arithmetic is unsigned, BIT_WIDTH bits. The carry-out of the top bit is the overflow source. There is no sign interpretation.

## Timing
- Reset values: acc_out=0, result_valid=0, overflow=0, data_ready=1, state IDLE, count=0.
- Reset mid-frame discards the partial sum immediately, without waiting for a clock edge.
- Accept-to-acc_out latency is 1 cycle.
- The last accept of a frame raises result_valid in the following cycle.
- Minimum frame time is NUM_SAMPLES accepts plus 1 DONE cycle. Continuous throughput is NUM_SAMPLES samples per NUM_SAMPLES+1 cycles.
- data_ready is a function of registered state only. There is no combinational path from data_valid to data_ready.
- Gaps in data_valid stall the frame indefinitely with no timeout. acc_out and count are held during a gap.

## Configuration
- Macro: ACC_SATURATE_EN.
- When defined:
  - An add producing a carry-out loads acc_out with all ones and sets overflow.
  - Later adds in that frame keep acc_out at all ones.
- When undefined: the sum wraps modulo 2^BIT_WIDTH and overflow is still set and sticky.
- The state machine and handshake behave identically in both builds.

## Structure
- Shared package sample_acc_pkg holds:
  - the state enum type (IDLE, ACCUM, DONE);
  - the default width and frame-length constants.
- One sub-module instance: adder_nbit, with BIT_WIDTH passed through.
  - a is acc_out, or 0 on the first sample of a frame.
  - b is data_in; carry_in is 0.
  - The sum and carry-out feed the next-state logic.
- All registers are in a single always_ff with asynchronous n_rst. Next-state and saturation logic are in always_comb.

## Test plan
- Basic frame (BIT_WIDTH=8, NUM_SAMPLES=4): samples 10, 20, 30, 40 back-to-back -> acc_out 10/30/60/100, result_valid high for one cycle, overflow=0, data_ready=0 in that cycle only.
- Overflow: samples 200, 100, 0, 0 -> without ACC_SATURATE_EN, final acc_out=44 and overflow=1. With ACC_SATURATE_EN, final acc_out=255 and overflow=1.
- Stalls and back-to-back frames: data_valid idle for 3 cycles between samples, then a second frame 1, 1, 1, 1 -> acc_out holds during stalls. The first frame total (100) stays on acc_out until the first accept of frame two. Frame two ends at 4 with overflow cleared.
- Clear mid-frame: after 2 samples (sum 30), pulse clear together with data_valid -> next cycle acc_out=0, count=0, IDLE. The concurrent sample is not accepted, and the following 4 samples complete a fresh frame.
- Asynchronous reset mid-frame: drop n_rst between clock edges after 3 samples -> outputs take their reset values immediately. After release, a full 4-sample frame completes normally.
